ifetch_unit: RTL and testbench

Instruction fetch and issue stage of the single-issue MIPS core. Holds the PC and fetches one word per instruction from instruction memory over a req/ack handshake. Presents the latched instruction and its decoded fields (opcode, funct, rs, rt, rd, immediate) to the control decoder and datapath. Applies the control decoder's Jump/Branch/JumpSel outputs to select the next PC, and halts on SYSCALL.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/ifetch_next_pc.sv | 40 ++++
 rtl/ifetch_unit.sv | 124 ++++++++++++
 tb/tb_ifetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct constants, fetch-state encoding, NOP word.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_ISSUE,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC select (JR / J / BNE / sequential) with alignment handling.
// IFETCH_ALIGN_CHECK_EN: report misaligned targets instead of silently clearing bits [1:0].
module ifetch_next_pc (
  input  logic [31:0] pc,
  input  logic [25:0] jump_index,
  input  logic [31:0] imm_sext,
  input  logic        jump,
  input  logic        branch,
  input  logic        jump_sel,
  input  logic        alu_zero,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    if (jump && jump_sel) begin
      target = reg_target;
    end else if (jump) begin
      target = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch && !alu_zero) begin
      target = pc_plus4 + {imm_sext[29:0], 2'b00};
    end else begin
      target = pc_plus4;
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    next_pc  = target;
    misalign = (target[1:0] != 2'b00);
`else
    next_pc  = target & ~32'h3;
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch/issue stage: REQ -> ISSUE -> REQ loop, halting on SYSCALL.
// IFETCH_ALIGN_CHECK_EN enables the misaligned-target fault (see ifetch_next_pc).
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        jump_sel,
  input  logic        alu_zero,
  input  logic [31:0] reg_target,
  output logic        halted,
  output logic        misalign_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         halted_q, halted_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  next_pc;
  logic         misalign;
  logic         is_syscall;

  assign instr          = instr_q;
  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign halted         = halted_q;
  assign misalign_fault = misalign_q;
  assign opcode         = instr_q[31:26];
  assign funct          = instr_q[5:0];
  assign rs             = instr_q[25:21];
  assign rt             = instr_q[20:16];
  assign rd             = instr_q[15:11];
  assign imm_sext       = {{16{instr_q[15]}}, instr_q[15:0]};
  assign is_syscall     = (opcode == OP_SPECIAL) && (funct == FN_SYSCALL);

  ifetch_next_pc u_next_pc (
    .pc         (pc_q),
    .jump_index (instr_q[25:0]),
    .imm_sext   (imm_sext),
    .jump       (jump),
    .branch     (branch),
    .jump_sel   (jump_sel),
    .alu_zero   (alu_zero),
    .reg_target (reg_target),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misalign   (misalign)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    halted_d    = halted_q;
    misalign_d  = misalign_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        // SYSCALL outranks any redirect; a faulting target also leaves pc in place
        if (instr_ready) begin
          if (is_syscall) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else if (misalign) begin
            misalign_d = 1'b1;
            halted_d   = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// against a PC-rule reference model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, pc, pc_plus4;
  logic        jump = 1'b0, branch = 1'b0, jump_sel = 1'b0, alu_zero = 1'b0;
  logic [31:0] reg_target = '0;
  logic        halted, misalign_fault;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm_sext(imm_sext), .pc(pc), .pc_plus4(pc_plus4),
    .jump(jump), .branch(branch), .jump_sel(jump_sel), .alu_zero(alu_zero),
    .reg_target(reg_target), .halted(halted), .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; jump_sel = 1'b0; alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Serve one fetch: wait for a request, hold off for 'waits' cycles, then ack.
  task automatic fetch(input logic [31:0] data, input int waits,
                       output logic [31:0] addr, output bit ok);
    int n;
    n = 0; ok = 1'b1;
    while (imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (imem_req !== 1'b1) begin ok = 1'b0; addr = 'x; return; end
    addr = imem_addr;
    repeat (waits) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== addr) ok = 1'b0;
    end
    imem_ack = 1'b1; imem_data = data;
    @(negedge clk);
    imem_ack = 1'b0; imem_data = $urandom;
  endtask

  // Present control inputs, stall 'delay' cycles, then accept the instruction.
  task automatic issue(input int delay, input logic j, input logic b, input logic js,
                       input logic z, input logic [31:0] tgt, output bit ok);
    int n;
    logic [31:0] held;
    n = 0; ok = 1'b1;
    while (instr_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (instr_valid !== 1'b1) begin ok = 1'b0; return; end
    held = instr;
    jump = j; branch = b; jump_sel = js; alu_zero = z; reg_target = tgt;
    repeat (delay) begin
      @(negedge clk);
      if (instr_valid !== 1'b1 || instr !== held || imem_req !== 1'b0) ok = 1'b0;
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; jump_sel = 1'b0; alu_zero = $urandom; reg_target = $urandom;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", instr, 32'h0); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (halted !== 1'b0 || misalign_fault !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", halted, misalign_fault); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h want 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_basic();
    logic [31:0] a; bit ok;
    do_reset();
    fetch(32'h2002_0005, 0, a, ok);
    checks++; if (!ok || a !== 32'h0) begin errors++; $display("FAIL basic_addr0 got %h ok=%0d want 00000000", a, ok); end
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h2002_0005) begin errors++; $display("FAIL basic_valid got %b/%h want 1/20020005", instr_valid, instr); end
    checks++; if (rs !== 5'd0 || rt !== 5'd2 || imm_sext !== 32'h5 || opcode !== 6'h08) begin errors++; $display("FAIL basic_fields got rs=%0d rt=%0d imm=%h op=%h want 0 2 00000005 08", rs, rt, imm_sext, opcode); end
    checks++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin errors++; $display("FAIL basic_pc got %h/%h want 0/4", pc, pc_plus4); end
    issue(0, 0, 0, 0, 0, 0, ok);
    checks++; if (!ok || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next got v=%b req=%b addr=%h want 0 1 00000004", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirects();
    logic [31:0] a; bit ok;
    do_reset();
    fetch(32'h0, 0, a, ok); issue(0, 0, 0, 0, 0, 0, ok);
    fetch(32'h0, 0, a, ok); issue(0, 0, 0, 0, 0, 0, ok);
    fetch({6'h02, 26'h10}, 0, a, ok);
    checks++; if (!ok || a !== 32'h8) begin errors++; $display("FAIL j_at got %h want 00000008", a); end
    issue(0, 1, 0, 0, 0, 32'hDEAD_BEEF, ok);
    fetch({6'h02, 26'h8}, 0, a, ok);
    checks++; if (!ok || a !== 32'h40) begin errors++; $display("FAIL j_target got %h want 00000040", a); end
    issue(0, 1, 0, 0, 0, 0, ok);
    fetch({6'h05, 5'd1, 5'd2, 16'hFFFE}, 0, a, ok);
    checks++; if (!ok || a !== 32'h20) begin errors++; $display("FAIL j2_target got %h want 00000020", a); end
    checks++; if (imm_sext !== 32'hFFFF_FFFE) begin errors++; $display("FAIL bne_imm got %h want fffffffe", imm_sext); end
    issue(1, 0, 1, 0, 0, 0, ok);
    fetch({6'h02, 26'h8}, 0, a, ok);
    checks++; if (!ok || a !== 32'h1C) begin errors++; $display("FAIL bne_taken got %h want 0000001c", a); end
    issue(0, 1, 0, 0, 0, 0, ok);
    fetch({6'h05, 5'd1, 5'd2, 16'hFFFE}, 0, a, ok); issue(0, 0, 1, 0, 1, 0, ok);
    fetch(32'h03E0_0008, 0, a, ok);
    checks++; if (!ok || a !== 32'h24) begin errors++; $display("FAIL bne_not_taken got %h want 00000024", a); end
    issue(0, 1, 0, 1, 0, 32'h100, ok);
    fetch(32'h03E0_0008, 0, a, ok);
    checks++; if (!ok || a !== 32'h100) begin errors++; $display("FAIL jr_target got %h want 00000100", a); end
    issue(0, 1, 0, 1, 0, 32'h102, ok);
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++; if (misalign_fault !== 1'b1 || halted !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL jr_misalign got mf=%b h=%b pc=%h want 1 1 00000100", misalign_fault, halted, pc); end
    begin
      int reqs; reqs = 0;
      repeat (20) begin @(negedge clk); if (imem_req !== 1'b0) reqs++; end
      checks++; if (reqs != 0) begin errors++; $display("FAIL misalign_noreq got %0d requests want 0", reqs); end
    end
`else
    checks++; if (!ok || misalign_fault !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL jr_forced_align got mf=%b h=%b addr=%h want 0 0 00000100", misalign_fault, halted, imem_addr); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] a; bit ok;
    do_reset();
    fetch(32'h03E0_0008, 0, a, ok); issue(0, 1, 0, 1, 0, 32'hFFFF_FFFC, ok);
    fetch(32'h0, 0, a, ok);
    checks++; if (!ok || a !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h want fffffffc/00000000", a, pc_plus4); end
    issue(0, 0, 0, 0, 0, 0, ok);
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got %h want 00000000", imem_addr); end
  endtask

  task automatic test_wait_states();
    logic [31:0] a; bit ok;
    do_reset();
    fetch(32'h8C22_0010, 3, a, ok);
    checks++; if (!ok || a !== 32'h0 || instr !== 32'h8C22_0010) begin errors++; $display("FAIL wait_fetch got ok=%0d addr=%h instr=%h want 1 0 8c220010", ok, a, instr); end
    issue(2, 0, 0, 0, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_stall_stable got %0d want 1", ok); end
    checks++; if (imem_addr !== 32'h4 || pc !== 32'h4) begin errors++; $display("FAIL wait_one_advance got %h want 00000004", imem_addr); end
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] a, w, mpc, tgt, sx; bit ok, ok2;
    logic j, b, js, z;
    int waits, dly;
    do_reset();
    mpc = 32'h0;
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if ((w >> 26) == 0 && (w & 32'h3F) == 32'h0C) w = w ^ 32'h1;
      waits = $urandom_range(0, 3);
      dly = $urandom_range(0, 2);
      fetch(w, waits, a, ok);
      checks++; if (!ok || a !== mpc) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, a, mpc); end
      sx = ((w & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      checks++;
      if (instr !== w || opcode !== 6'(w >> 26) || funct !== 6'(w & 63) || rs !== 5'((w >> 21) & 31) ||
          rt !== 5'((w >> 16) & 31) || rd !== 5'((w >> 11) & 31) || imm_sext !== sx || pc !== mpc || pc_plus4 !== mpc + 4) begin
        errors++; $display("FAIL rnd_fields[%0d] got instr=%h imm=%h pc=%h want %h %h %h", i, instr, imm_sext, pc, w, sx, mpc);
      end
      j = $urandom; b = $urandom; js = $urandom; z = $urandom; tgt = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
      tgt = tgt & ~32'h3;
`endif
      if (j && js) mpc = tgt & ~32'h3;
      else if (j) mpc = ((mpc + 4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
      else if (b && !z) mpc = mpc + 4 + sx * 4;
      else mpc = mpc + 4;
      issue(dly, j, b, js, z, tgt, ok2);
      checks++; if (!ok2) begin errors++; $display("FAIL rnd_issue[%0d] got %0d want 1", i, ok2); end
    end
  endtask

  task automatic test_syscall();
    logic [31:0] a; bit ok;
    int reqs;
    do_reset();
    fetch(32'h0, 0, a, ok); issue(0, 0, 0, 0, 0, 0, ok);
    fetch(32'h0000_000C, 0, a, ok); issue(1, 1, 0, 1, 0, 32'h200, ok);
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h4) begin errors++; $display("FAIL syscall_halt got h=%b v=%b pc=%h want 1 0 00000004", halted, instr_valid, pc); end
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = (i % 3 == 0); instr_ready = (i % 2 == 0);
      @(negedge clk);
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) reqs++;
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    checks++; if (reqs != 0 || instr !== 32'h0000_000C) begin errors++; $display("FAIL syscall_quiet got %0d active cycles instr=%h want 0 0000000c", reqs, instr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; bit ok;
    do_reset();
    fetch(32'h0, 0, a, ok); issue(0, 0, 0, 0, 0, 0, ok);
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b1; imem_data = 32'h1234_5678;
    #1;
    checks++; if (pc !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_async got pc=%h v=%b want 00000000 0", pc, instr_valid); end
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_release got req=%b addr=%h instr=%h want 1 0 0", imem_req, imem_addr, instr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirects();
    test_wrap();
    test_wait_states();
    test_back_to_back_random();
    test_syscall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
